// File: rtl/bus_frame_rx.sv
// bus_frame_rx: assembles eight bus bytes into a 64-bit frame word for the
// comparator channel input. It aborts restarted or stalled frames and keeps
// counters of good and aborted frames.
module bus_frame_rx #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned GAP_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rxData,
  input  logic        rxValid,
  input  logic        rxSof,
  output logic [63:0] dataOut,
  output logic        dataEn,
  output logic        frameErr,
  output logic [15:0] frameCnt,
  output logic [7:0]  errCnt,
  output logic        busy
);

  localparam int unsigned FRAME_W = 64;
  // Only the first seven bytes are ever held. The eighth byte goes straight into dataOut.
  localparam int unsigned SH_W    = 56;
  localparam int unsigned BCNT_W  = 3;
  localparam int unsigned FCNT_W  = 16;
  localparam int unsigned ECNT_W  = 8;

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [SH_W-1:0]     sh_q, sh_d;
  logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [FRAME_W-1:0]  data_out_q, data_out_d;
  logic                data_en_q, data_en_d;
  logic                frame_err_q, frame_err_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [ECNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [GAP_W-1:0]    gap_inc;
  logic [ECNT_W-1:0]   err_sat;

  assign gap_inc = gap_cnt_q + GAP_W'(1);
  assign err_sat = (err_cnt_q == {ECNT_W{1'b1}}) ? err_cnt_q : err_cnt_q + ECNT_W'(1);

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    byte_cnt_d  = byte_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    data_out_d  = data_out_q;
    data_en_d   = 1'b0;
    frame_err_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;

    if (state_q == IDLE) begin
      // In IDLE, a byte without SOF is dropped silently.
      if (rxValid && rxSof) begin
        sh_d       = {48'b0, rxData};
        byte_cnt_d = BCNT_W'(1);
        gap_cnt_d  = '0;
        state_d    = RECV;
      end
    end else begin
      if (rxValid && rxSof) begin
        // A new SOF restarts the frame. The partial frame counts as an error.
        frame_err_d = 1'b1;
        err_cnt_d   = err_sat;
        sh_d        = {48'b0, rxData};
        byte_cnt_d  = BCNT_W'(1);
        gap_cnt_d   = '0;
      end else if (rxValid && (byte_cnt_q != BCNT_W'(7))) begin
        sh_d       = {sh_q[47:0], rxData};
        byte_cnt_d = byte_cnt_q + BCNT_W'(1);
        gap_cnt_d  = '0;
      end else if (rxValid) begin
        data_out_d  = {sh_q, rxData};
        data_en_d   = 1'b1;
        frame_cnt_d = frame_cnt_q + FCNT_W'(1);
        byte_cnt_d  = '0;
        gap_cnt_d   = '0;
        state_d     = IDLE;
      end else begin
        gap_cnt_d = gap_inc;
        if (gap_inc == GAP_W'(TIMEOUT)) begin
          frame_err_d = 1'b1;
          err_cnt_d   = err_sat;
          byte_cnt_d  = '0;
          gap_cnt_d   = '0;
          state_d     = IDLE;
        end
      end
    end
  end

  // State and output registers. An asynchronous reset drops any partial frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      byte_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      data_out_q  <= '0;
      data_en_q   <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      byte_cnt_q  <= byte_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      data_out_q  <= data_out_d;
      data_en_q   <= data_en_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign dataOut  = data_out_q;
  assign dataEn   = data_en_q;
  assign frameErr = frame_err_q;
  assign frameCnt = frame_cnt_q;
  assign errCnt   = err_cnt_q;
  assign busy     = (state_q == RECV);

endmodule

// File: tb/tb_bus_frame_rx.sv
// Testbench for bus_frame_rx, built with TIMEOUT=4. Expected frame words and
// error pulses are queued with their edge numbers, then matched against the
// DUT outputs.
module tb_bus_frame_rx;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        rxSof;
  logic [63:0] dataOut;
  logic        dataEn;
  logic        frameErr;
  logic [15:0] frameCnt;
  logic [7:0]  errCnt;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  int          en_cyc_q[$];
  logic [63:0] en_dat_q[$];
  int          err_cyc_q[$];

  bus_frame_rx #(.TIMEOUT(TO), .GAP_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .rxData   (rxData),
    .rxValid  (rxValid),
    .rxSof    (rxSof),
    .dataOut  (dataOut),
    .dataEn   (dataEn),
    .frameErr (frameErr),
    .frameCnt (frameCnt),
    .errCnt   (errCnt),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Count edges, then compare the output pulses against the queued expectations.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (dataEn || frameErr) check("en_err_exclusive", 64'(dataEn & frameErr), 64'd0);
    if (dataEn) begin
      if (en_cyc_q.size() == 0) check("dataEn_unexpected", 64'd1, 64'd0);
      else begin
        check("dataEn_edge", 64'(cyc), 64'(en_cyc_q.pop_front()));
        check("dataOut", dataOut, en_dat_q.pop_front());
      end
    end
    if (frameErr) begin
      if (err_cyc_q.size() == 0) check("frameErr_unexpected", 64'd1, 64'd0);
      else check("frameErr_edge", 64'(cyc), 64'(err_cyc_q.pop_front()));
    end
  end

  // Drive one cycle of input and return just after the edge that samples it.
  task automatic step(input logic v, input logic s, input logic [7:0] d);
    @(negedge clk);
    rxValid = v;
    rxSof   = s;
    rxData  = d;
    @(posedge clk);
    #1;
  endtask

  // Send a full frame, with an optional idle gap between bytes 4 and 5.
  task automatic send_frame(input logic [63:0] w, input int gap);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'h00);
      if (i == 7) begin
        en_cyc_q.push_back(cyc + 1);
        en_dat_q.push_back(w);
      end
      step(1'b1, (i == 0), w[63-8*i -: 8]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b0; rxValid = 1'b0; rxSof = 1'b0; rxData = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dataOut", dataOut, 64'd0);
    check("rst_flags", {61'd0, dataEn, frameErr, busy}, 64'd0);
    check("rst_counts", {40'd0, frameCnt, errCnt}, 64'd0);
    @(negedge clk) rst = 1'b1;

    // Plain frame on consecutive cycles.
    send_frame(64'h1122334455667788, 0);
    idle(2);
    check("f1_frameCnt", 64'(frameCnt), 64'd1);
    check("f1_dataOut", dataOut, 64'h1122334455667788);
    check("f1_busy", 64'(busy), 64'd0);

    // Idle gap one cycle short of the timeout.
    send_frame(64'h1122334455667788, TO - 1);
    idle(1);
    check("gap_frameCnt", 64'(frameCnt), 64'd2);
    check("gap_errCnt", 64'(errCnt), 64'd0);

    // Restart after five bytes.
    step(1'b1, 1'b1, 8'h51);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h52 + i));
    err_cyc_q.push_back(cyc + 1);
    send_frame(64'hA0A1A2A3A4A5A6A7, 0);
    idle(1);
    check("rs_errCnt", 64'(errCnt), 64'd1);
    check("rs_frameCnt", 64'(frameCnt), 64'd3);
    check("rs_dataOut", dataOut, 64'hA0A1A2A3A4A5A6A7);

    // Timeout: three bytes, then idle until the frame is aborted.
    step(1'b1, 1'b1, 8'hC1);
    step(1'b1, 1'b0, 8'hC2);
    step(1'b1, 1'b0, 8'hC3);
    err_cyc_q.push_back(cyc + TO);
    idle(TO - 1);
    check("to_busy_before", 64'(busy), 64'd1);
    idle(1);
    check("to_busy_after", 64'(busy), 64'd0);
    check("to_errCnt", 64'(errCnt), 64'd2);
    step(1'b1, 1'b0, 8'hEE);
    check("to_stray_busy", 64'(busy), 64'd0);
    idle(2);
    check("to_dataOut_held", dataOut, 64'hA0A1A2A3A4A5A6A7);

    // Back-to-back frames with no dead cycle.
    send_frame(64'h0102030405060708, 0);
    send_frame(64'h1112131415161718, 0);
    idle(1);
    check("b2b_frameCnt", 64'(frameCnt), 64'd5);
    check("b2b_dataOut", dataOut, 64'h1112131415161718);

    // 300 restarts push errCnt into saturation.
    step(1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 300; i++) begin
      err_cyc_q.push_back(cyc + 1);
      step(1'b1, 1'b1, 8'(i));
    end
    check("sat_errCnt", 64'(errCnt), 64'hFF);
    err_cyc_q.push_back(cyc + TO);
    idle(TO + 1);
    check("sat_hold_errCnt", 64'(errCnt), 64'hFF);
    check("sat_frameCnt", 64'(frameCnt), 64'd5);

    // Asynchronous reset after six bytes.
    step(1'b1, 1'b1, 8'h61);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h62 + i));
    #2 rst = 1'b0;
    #1;
    check("arst_dataOut", dataOut, 64'd0);
    check("arst_flags", {61'd0, dataEn, frameErr, busy}, 64'd0);
    check("arst_counts", {40'd0, frameCnt, errCnt}, 64'd0);
    @(negedge clk) rst = 1'b1;
    send_frame(64'hDEADBEEFCAFEF00D, 0);
    idle(2);
    check("post_frameCnt", 64'(frameCnt), 64'd1);
    check("post_errCnt", 64'(errCnt), 64'd0);
    check("post_dataOut", dataOut, 64'hDEADBEEFCAFEF00D);

    idle(2);
    check("en_q_drained", 64'(en_cyc_q.size()), 64'd0);
    check("err_q_drained", 64'(err_cyc_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Hard stop if the run never reaches its summary.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_frame_rx.md
# bus_frame_rx

Byte-stream frame receiver for the bus comparator front end. It assembles eight consecutive bus bytes into one 64-bit frame word: 48-bit payload in bits [63:16], CRC16 in bits [15:0]. It presents the word with a one-cycle enable pulse to the comparator channel input pair (`dataIn`/`dataEn`). It also detects restarted and stalled frames and keeps good-frame and error counters for diagnostics.

## Interface
Parameters:
- `TIMEOUT`, 255: consecutive idle cycles inside a frame before it is aborted; legal range 1..65535.
- `GAP_W`, 16: width of the internal gap counter; must hold `TIMEOUT`.

Ports:
- `clk` in 1: single system clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-low. Same name as the rest of the comparator design; the polarity and synchronicity stated here are fixed for this block.
- `rxData` in 8: incoming bus byte.
- `rxValid` in 1: `rxData` is valid this cycle; a byte is accepted on any edge with `rxValid`=1.
- `rxSof` in 1: start of frame; qualified by `rxValid`.
- `dataOut` out 64: last complete frame; first received byte in [63:56]. Reset 0.
- `dataEn` out 1: one-cycle pulse, new `dataOut` valid. Reset 0.
- `frameErr` out 1: one-cycle pulse, frame aborted. Reset 0.
- `frameCnt` out 16: good frames delivered; wraps 0xFFFF→0. Reset 0.
- `errCnt` out 8: aborted frames; saturates at 0xFF. Reset 0.
- `busy` out 1: 1 while in RECV. Reset 0.

## Operation
- Two states, IDLE and RECV. Internal signals:
  - `shReg[63:0]`: assembly shift register.
  - `byteCnt[2:0]`: bytes held in the current frame.
  - `gapCnt[GAP_W-1:0]`: consecutive idle cycles in RECV.
- IDLE:
  - `rxValid`&`rxSof` → `shReg` <= {56'b0, `rxData`}, `byteCnt` <= 1, `gapCnt` <= 0, go to RECV.
  - `rxValid` without `rxSof` → byte discarded, no error.
- RECV, evaluated in this priority:
  1. `rxValid`&`rxSof`: restart. Pulse `frameErr`, `errCnt`+1 (saturating). Reload as in IDLE, stay in RECV.
  2. `rxValid` with `byteCnt`<7: `shReg` <= {`shReg`[55:0], `rxData`}, `byteCnt`+1, `gapCnt` <= 0.
  3. `rxValid` with `byteCnt`==7: `dataOut` <= {`shReg`[55:0], `rxData`}, pulse `dataEn`, `frameCnt`+1, clear `byteCnt` and `gapCnt`, go to IDLE.
  4. `rxValid`=0: `gapCnt`+1. If the incremented value equals `TIMEOUT`: pulse `frameErr`, `errCnt`+1 (saturating), clear `byteCnt` and `gapCnt`, go to IDLE.
- `dataOut` changes only on completion. It is held between frames and on abort.
- `shReg` contents after an abort are don't-care; the next SOF reloads them.
- `busy` = (state == RECV).

## Timing
- All outputs are registered.
- Completion: 8th byte accepted at edge N → `dataOut` and `frameCnt` updated and `dataEn`=1 from edge N. `dataEn` returns to 0 at edge N+1, unless another frame completes at N+1, which is impossible because a frame needs 8 accepted bytes.
- Minimum frame spacing: 8 cycles. Back-to-back frames (SOF on the cycle after the 8th byte) must be accepted with no dead cycle.
- Timeout: last byte at edge M, `rxValid`=0 afterwards → `frameErr` high from edge M+`TIMEOUT`, for one cycle.
  - With `TIMEOUT`=1, the first idle cycle aborts.
  - A byte arriving on edge M+`TIMEOUT`+1 is treated as in IDLE.
- `frameErr` and `dataEn` are never high in the same cycle.
- Asynchronous `rst` assertion mid-frame clears all state and outputs immediately. The partial frame is lost and no error is counted.
- After reset release, the first edge with `rxValid`&`rxSof` starts a frame.

## Test plan
- Reset, then SOF+bytes 0x11,0x22,…,0x88 on 8 consecutive cycles:
  - `dataOut`=0x1122334455667788.
  - `dataEn` high exactly 1 cycle, starting at the edge of byte 8.
  - `frameCnt`=1, `frameErr` never high.
- Same frame with 3 idle cycles between bytes 4 and 5 (`TIMEOUT`=255) → identical `dataOut` and a single `dataEn` pulse.
- SOF, 5 bytes, new SOF with 0xA0, then 7 more bytes 0xA1..0xA7:
  - `frameErr` pulse at the second SOF, `errCnt`=1.
  - `dataOut`=0xA0A1A2A3A4A5A6A7.
- `TIMEOUT`=4: SOF, 3 bytes, idle:
  - `frameErr` pulse exactly 4 edges after the 3rd byte, `busy` falls with it.
  - A later non-SOF byte is ignored; `dataOut` is unchanged from its previous value.
- Two frames back-to-back, then 300 SOF-restart aborts:
  - `frameCnt`=2, both `dataEn` pulses present.
  - `errCnt` saturates at 0xFF.
- Assert `rst` after 6 bytes of a frame:
  - All outputs are 0 asynchronously.
  - After release, a full frame completes normally with `frameCnt`=1 and `errCnt`=0.
